// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD timer path: FSM states, the BCD digit type
// and the conversion of a binary limit into a tens/ones pair.
package timer_pkg;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_e;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t ones;
  } bcd_pair_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Splits a binary value in 0..99 into its BCD tens/ones digits (elaboration-time use).
  function automatic bcd_pair_t to_bcd(input int unsigned value);
    bcd_pair_t r;
    r.tens = bcd_digit_t'((value / 10) % 10);
    r.ones = bcd_digit_t'(value % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit down-counter: loads a preset, decrements on dec, and reloads
// wrap_val with a borrow when decremented from 0.
module bcd_digit_down
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       dec,
  input  logic       load,
  input  bcd_digit_t load_val,
  input  bcd_digit_t wrap_val,
  output bcd_digit_t digit,
  output logic       borrow
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = load_val;
    end else if (dec) begin
      digit_d = (digit_q == 4'd0) ? wrap_val : digit_q - 4'd1;
    end
  end

  // NOTE: state flops use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit  = digit_q;
  assign borrow = dec && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_60.sv
// Two-digit BCD countdown with IDLE/RUN/EXPIRED control, wrap-or-stop at 00.
// Define COUNTDOWN_LOAD_CHECK_EN to reject non-BCD or out-of-range preset loads.
module bcd_countdown_60
  import timer_pkg::*;
#(
  parameter int unsigned MODULUS = 60,
  parameter bit          WRAP    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  input  logic       load,
  input  logic [3:0] load_q1,
  input  logic [3:0] load_q2,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] out_q1,
  output logic [3:0] out_q2,
  output logic       out_borrow,
  output logic       done,
  output logic       expired,
  output logic       busy,
  output logic       load_err
);

  localparam bcd_pair_t TOP = to_bcd(MODULUS - 1);

  state_e     state_q, state_d;
  logic       done_q, done_d;
  logic       borrow_q, borrow_d;
  logic       load_err_q, load_err_d;

  logic       load_ok;
  logic       load_en;
  logic       cnt_zero;
  logic       reach_zero;
  logic       dec_ones;
  logic       ones_borrow;
  logic       tens_borrow;
  bcd_digit_t ones_wrap;

`ifdef COUNTDOWN_LOAD_CHECK_EN
  // Range check is per digit: value <= MODULUS-1 without forming 10*tens+ones.
  assign load_ok = (load_q1 <= BCD_MAX) && (load_q2 <= BCD_MAX) &&
                   ((load_q1 < TOP.tens) || ((load_q1 == TOP.tens) && (load_q2 <= TOP.ones)));
`else
  assign load_ok = 1'b1;
`endif

  assign load_en    = load && load_ok;
  assign cnt_zero   = (out_q1 == 4'd0) && (out_q2 == 4'd0);
  assign reach_zero = (out_q1 == 4'd0) && (out_q2 == 4'd1);
  assign dec_ones   = (state_q == RUN) && in && !load && !stop && (!cnt_zero || WRAP);
  // Ones reloads 9 on a normal borrow, but the modulus ones digit when the whole count wraps.
  assign ones_wrap  = cnt_zero ? TOP.ones : BCD_MAX;

  bcd_digit_down u_ones (
    .clk      (clk),
    .rst      (rst),
    .dec      (dec_ones),
    .load     (load_en),
    .load_val (load_q2),
    .wrap_val (ones_wrap),
    .digit    (out_q2),
    .borrow   (ones_borrow)
  );

  bcd_digit_down u_tens (
    .clk      (clk),
    .rst      (rst),
    .dec      (ones_borrow),
    .load     (load_en),
    .load_val (load_q1),
    .wrap_val (TOP.tens),
    .digit    (out_q1),
    .borrow   (tens_borrow)
  );

  always_comb begin
    state_d    = state_q;
    done_d     = 1'b0;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok) state_d = IDLE;
      else         load_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (!cnt_zero || WRAP) begin
              state_d = RUN;
            end else begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state_d = IDLE;
          end else if (dec_ones) begin
            borrow_d = WRAP && tens_borrow;
            if (reach_zero && !WRAP) begin
              state_d = EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        EXPIRED: state_d = EXPIRED;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      done_q     <= 1'b0;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign out_borrow = borrow_q;
  assign done       = done_q;
  assign load_err   = load_err_q;
  assign busy       = (state_q == RUN);
  assign expired    = (state_q == EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_60.sv
// Self-checking bench: a wrapping and a stopping countdown share stimulus and are
// compared every cycle against an integer-valued reference model.
module tb_bcd_countdown_60;

  localparam int MOD = 60;
`ifdef COUNTDOWN_LOAD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef enum int {M_IDLE, M_RUN, M_EXP} mstate_e;

  logic       clk = 1'b0;
  logic       rst, in_tick, load, start, stop;
  logic [3:0] lq1, lq2;

  logic [3:0] w_q1, w_q2, s_q1, s_q2;
  logic       w_bor, w_done, w_exp, w_busy, w_err;
  logic       s_bor, s_done, s_exp, s_busy, s_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: index 0 = wrapping instance, index 1 = stopping instance.
  int      m_val  [2];
  mstate_e m_st   [2];
  bit      m_done [2];
  bit      m_bor  [2];
  bit      m_err  [2];

  always #5 clk = ~clk;

  bcd_countdown_60 #(.MODULUS(MOD), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .in(in_tick), .load(load), .load_q1(lq1), .load_q2(lq2),
    .start(start), .stop(stop), .out_q1(w_q1), .out_q2(w_q2), .out_borrow(w_bor),
    .done(w_done), .expired(w_exp), .busy(w_busy), .load_err(w_err)
  );

  bcd_countdown_60 #(.MODULUS(MOD), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .in(in_tick), .load(load), .load_q1(lq1), .load_q2(lq2),
    .start(start), .stop(stop), .out_q1(s_q1), .out_q2(s_q2), .out_borrow(s_bor),
    .done(s_done), .expired(s_exp), .busy(s_busy), .load_err(s_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    bit wrap;
    int lv;
    wrap      = (i == 0);
    lv        = int'(lq1) * 10 + int'(lq2);
    m_done[i] = 1'b0;
    m_bor[i]  = 1'b0;
    m_err[i]  = 1'b0;
    if (rst) begin
      m_val[i] = 0;
      m_st[i]  = M_IDLE;
    end else if (load) begin
      if (CHK && (lq1 > 9 || lq2 > 9 || lv >= MOD)) begin
        m_err[i] = 1'b1;
      end else begin
        m_val[i] = lv;
        m_st[i]  = M_IDLE;
      end
    end else if (m_st[i] == M_IDLE) begin
      if (start) begin
        if (m_val[i] != 0 || wrap) begin
          m_st[i] = M_RUN;
        end else begin
          m_st[i]   = M_EXP;
          m_done[i] = 1'b1;
        end
      end
    end else if (m_st[i] == M_RUN) begin
      if (stop) begin
        m_st[i] = M_IDLE;
      end else if (in_tick) begin
        if (m_val[i] == 0) begin
          m_val[i] = MOD - 1;
          m_bor[i] = 1'b1;
        end else begin
          m_val[i] = m_val[i] - 1;
          if (m_val[i] == 0 && !wrap) begin
            m_st[i]   = M_EXP;
            m_done[i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] exp_cnt;
    logic [4:0] exp_flg;
    for (int i = 0; i < 2; i++) begin
      exp_cnt = {4'(m_val[i] / 10), 4'(m_val[i] % 10)};
      exp_flg = {m_st[i] == M_RUN, m_st[i] == M_EXP, m_done[i], m_bor[i], m_err[i]};
      if (i == 0) begin
        check("wrap.count", {24'd0, w_q1, w_q2}, {24'd0, exp_cnt});
        check("wrap.flags{busy,exp,done,bor,err}", {27'd0, w_busy, w_exp, w_done, w_bor, w_err},
              {27'd0, exp_flg});
      end else begin
        check("stop.count", {24'd0, s_q1, s_q2}, {24'd0, exp_cnt});
        check("stop.flags{busy,exp,done,bor,err}", {27'd0, s_busy, s_exp, s_done, s_bor, s_err},
              {27'd0, exp_flg});
      end
    end
  endtask

  // Apply inputs, clock once, advance the model and compare 1 time unit after the edge.
  task automatic cyc(input bit r, input bit l, input logic [3:0] t, input logic [3:0] o,
                     input bit sta, input bit sto, input bit tk);
    rst = r; load = l; lq1 = t; lq2 = o; start = sta; stop = sto; in_tick = tk;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; lq1 = 4'd0; lq2 = 4'd0; start = 1'b0; stop = 1'b0; in_tick = 1'b0;
    cyc(1, 0, 4'd0, 4'd0, 0, 0, 0);
    cyc(1, 0, 4'd0, 4'd0, 0, 0, 0);
    check("reset.busy", {31'd0, w_busy}, 32'd0);

    // Reset in the middle of a run at 37.
    cyc(0, 1, 4'd3, 4'd7, 0, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    cyc(1, 0, 4'd0, 4'd0, 0, 0, 1);
    check("rst_mid_run.count", {24'd0, w_q1, w_q2}, 32'h00);

    // 12 -> 11 -> 10 -> 09.
    cyc(0, 1, 4'd1, 4'd2, 0, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    check("tens_borrow.count", {24'd0, w_q1, w_q2}, 32'h09);

    // Wrap from 00 to 59, then 58; the stopping instance expires on start at 00.
    cyc(0, 1, 4'd0, 4'd0, 0, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    check("start_at_00.done", {31'd0, s_done}, 32'd1);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    check("wrap.count59", {24'd0, w_q1, w_q2}, 32'h59);
    check("wrap.borrow", {31'd0, w_bor}, 32'd1);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    check("wrap.borrow_cleared", {31'd0, w_bor}, 32'd0);

    // 02 -> 01 -> 00 (done, expired), then in/start ignored, load 05 leaves EXPIRED.
    cyc(0, 1, 4'd0, 4'd2, 0, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    check("expire.expired", {31'd0, s_exp}, 32'd1);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    cyc(0, 1, 4'd0, 4'd5, 0, 0, 0);
    check("reload.expired", {31'd0, s_exp}, 32'd0);

    // Stop beats in; start is not combined with a decrement.
    cyc(0, 1, 4'd4, 4'd5, 0, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 0);
    cyc(0, 0, 4'd0, 4'd0, 0, 1, 1);
    cyc(0, 0, 4'd0, 4'd0, 1, 0, 1);
    check("start_with_in.count", {24'd0, w_q1, w_q2}, 32'h45);
    cyc(0, 0, 4'd0, 4'd0, 0, 0, 1);
    check("resume.count", {24'd0, w_q1, w_q2}, 32'h44);

    // Out-of-range loads: rejected with the check enabled, accepted raw otherwise.
    if (CHK) cyc(0, 1, 4'd6, 4'hA, 0, 0, 0);
    cyc(0, 1, 4'd6, 4'd0, 0, 0, 0);
    idle_cyc();

    // Randomised traffic with legal presets.
    for (int n = 0; n < 3000; n++) begin
      int v;
      v = int'($urandom_range(MOD - 1, 0));
      cyc(($urandom_range(99, 0) == 0), ($urandom_range(19, 0) == 0),
          4'(v / 10), 4'(v % 10),
          ($urandom_range(7, 0) == 0), ($urandom_range(15, 0) == 0),
          ($urandom_range(1, 0) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
